player_ctl: RTL and testbench

- Per-frame position controller for the player sprite. Produces the 9-bit xpos/ypos that the rectangle-drawing stage consumes.
- Samples button levels and updates position once per frame, on the vsync rising edge.
- Implements horizontal movement with clamping and a vertical jump/gravity state machine.

---
 rtl/player_ctl_pkg.sv | 13 +
 rtl/player_ctl_rise.sv | 22 ++
 rtl/player_ctl.sv | 166 ++++++++++++++++
 tb/tb_player_ctl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_ctl_pkg.sv
// Shared types and widths for the player sprite position controller.
package player_ctl_pkg;

  localparam int POS_W = 9;
  localparam int VEL_W = 8;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

endpackage

// File: rtl/player_ctl_rise.sv
// Rising-edge detector: one registered delay stage plus AND-NOT.
module rise_edge (
  input  logic pclk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_d;

  // previous-cycle copy of the input level
  always_ff @(posedge pclk) begin
    if (rst) begin
      din_d <= 1'b0;
    end else begin
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/player_ctl.sv
// Per-frame sprite position controller: horizontal clamp plus jump/gravity FSM.
// Optional mid-air second jump is enabled by defining PLAYER_CTL_DOUBLE_JUMP_EN.
module player_ctl
  import player_ctl_pkg::*;
#(
  parameter int X_INIT   = 160,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 320,
  parameter int X_STEP   = 4,
  parameter int Y_FLOOR  = 220,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1,
  parameter int VEL_MAX  = 10
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             game_en,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             airborne,
  output logic             landed
);

  localparam logic [9:0]       X_MIN_W   = 10'(X_MIN);
  localparam logic [9:0]       X_MAX_W   = 10'(X_MAX);
  localparam logic [9:0]       X_STEP_W  = 10'(X_STEP);
  localparam logic [9:0]       Y_FLOOR_W = 10'(Y_FLOOR);
  localparam logic [VEL_W-1:0] JUMP_V    = VEL_W'(JUMP_VEL);
  localparam logic [VEL_W-1:0] GRAV_V    = VEL_W'(GRAVITY);
  localparam logic [VEL_W-1:0] VEL_MAX_V = VEL_W'(VEL_MAX);

  logic             tick, jump_edge, jump_now, dbl_go;
  logic             jump_req, jump_req_nxt, landed_nxt;
  state_t           state, state_nxt;
  logic [VEL_W-1:0] vel, vel_nxt;
  logic [POS_W-1:0] xpos_nxt, ypos_nxt;
  logic [9:0]       x_ext, x_up, y_sum;
  logic [VEL_W:0]   vel_up;

  rise_edge u_vsync_edge (.pclk(pclk), .rst(rst), .din(vsync),    .rise(tick));
  rise_edge u_jump_edge  (.pclk(pclk), .rst(rst), .din(btn_jump), .rise(jump_edge));

  // an edge arriving in the tick cycle itself still counts for that tick
  assign jump_now = jump_req | jump_edge;
  assign airborne = (state != GROUND);

`ifdef PLAYER_CTL_DOUBLE_JUMP_EN
  logic double_avail, dbl_nxt;

  assign dbl_go = jump_now & double_avail & (state != GROUND);

  // second-jump credit: spent on use, restored on landing
  always_comb begin
    dbl_nxt = double_avail;
    if (tick && game_en && dbl_go) begin
      dbl_nxt = 1'b0;
    end else if (landed_nxt) begin
      dbl_nxt = 1'b1;
    end else begin
      dbl_nxt = double_avail;
    end
  end

  // second-jump credit register
  always_ff @(posedge pclk) begin
    if (rst) begin
      double_avail <= 1'b1;
    end else begin
      double_avail <= dbl_nxt;
    end
  end
`else
  assign dbl_go = 1'b0;
`endif

  // per-frame position and vertical state update
  always_comb begin
    state_nxt    = state;
    vel_nxt      = vel;
    xpos_nxt     = xpos;
    ypos_nxt     = ypos;
    landed_nxt   = 1'b0;
    jump_req_nxt = tick ? 1'b0 : jump_now;
    x_ext        = {1'b0, xpos};
    x_up         = x_ext + X_STEP_W;
    y_sum        = {1'b0, ypos} + {2'b00, vel};
    vel_up       = {1'b0, vel} + {1'b0, GRAV_V};
    if (tick && game_en) begin
      if (btn_left && !btn_right) begin
        xpos_nxt = (x_ext < X_MIN_W + X_STEP_W) ? POS_W'(X_MIN_W) : POS_W'(x_ext - X_STEP_W);
      end else if (btn_right && !btn_left) begin
        xpos_nxt = (x_up > X_MAX_W) ? POS_W'(X_MAX_W) : x_up[POS_W-1:0];
      end else begin
        xpos_nxt = xpos;
      end
      case (state)
        GROUND: begin
          if (jump_now) begin
            state_nxt = RISE;
            vel_nxt   = JUMP_V;
          end else begin
            state_nxt = GROUND;
          end
        end
        RISE, FALL: begin
          if (dbl_go) begin
            state_nxt = RISE;
            vel_nxt   = JUMP_V;
          end else if (state == RISE) begin
            if ({1'b0, vel} > ypos) begin
              ypos_nxt  = '0;
              state_nxt = FALL;
              vel_nxt   = '0;
            end else begin
              ypos_nxt = ypos - {1'b0, vel};
              if (vel <= GRAV_V) begin
                state_nxt = FALL;
                vel_nxt   = '0;
              end else begin
                vel_nxt = vel - GRAV_V;
              end
            end
          end else if (y_sum >= Y_FLOOR_W) begin
            ypos_nxt   = POS_W'(Y_FLOOR_W);
            vel_nxt    = '0;
            state_nxt  = GROUND;
            landed_nxt = 1'b1;
          end else begin
            ypos_nxt = y_sum[POS_W-1:0];
            vel_nxt  = (vel_up > {1'b0, VEL_MAX_V}) ? VEL_MAX_V : vel_up[VEL_W-1:0];
          end
        end
        default: begin
          state_nxt = GROUND;
          vel_nxt   = '0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // state and output registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= GROUND;
      vel      <= '0;
      jump_req <= 1'b0;
      xpos     <= POS_W'(X_INIT);
      ypos     <= POS_W'(Y_FLOOR);
      landed   <= 1'b0;
    end else begin
      state    <= state_nxt;
      vel      <= vel_nxt;
      jump_req <= jump_req_nxt;
      xpos     <= xpos_nxt;
      ypos     <= ypos_nxt;
      landed   <= landed_nxt;
    end
  end

endmodule

// File: tb/tb_player_ctl.sv
// Self-checking bench for player_ctl against a frame-level behavioural model.
module tb_player_ctl;

  localparam int XI = 160, XMIN = 0, XMAX = 320, XS = 4;
  localparam int YF = 220, JV = 12, G = 1, VM = 10;
`ifdef PLAYER_CTL_DOUBLE_JUMP_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic       pclk = 1'b0, rst = 1'b0, vsync = 1'b0, game_en = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, c_jump = 1'b0;
  logic [8:0] xpos, ypos, cx, cy;
  logic       airborne, landed, cair, clnd;

  int n_checks = 0, n_fail = 0;

  // model: mst 0=on ground, 1=moving up, 2=moving down
  int mx, my, mst, mvel;
  bit mjreq, mdbl, mland, prev_j;
  logic obs_land, obs_land2, obs_cland;

  player_ctl dut (
    .pclk(pclk), .rst(rst), .vsync(vsync), .game_en(game_en),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .xpos(xpos), .ypos(ypos), .airborne(airborne), .landed(landed)
  );

  player_ctl #(.JUMP_VEL(250), .Y_FLOOR(100)) dut_c (
    .pclk(pclk), .rst(rst), .vsync(vsync), .game_en(game_en),
    .btn_left(1'b0), .btn_right(1'b0), .btn_jump(c_jump),
    .xpos(cx), .ypos(cy), .airborne(cair), .landed(clnd)
  );

  always #5 pclk = ~pclk;

  task automatic model_reset();
    mx = XI; my = YF; mst = 0; mvel = 0; mjreq = 0; mdbl = 1; mland = 0; prev_j = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit en);
    mland = 0;
    if (en) begin
      if (l && !r) mx = (mx - XS < XMIN) ? XMIN : mx - XS;
      else if (r && !l) mx = (mx + XS > XMAX) ? XMAX : mx + XS;
      if (mst == 0) begin
        if (mjreq) begin mst = 1; mvel = JV; end
      end else if (DBL && mjreq && mdbl) begin
        mst = 1; mvel = JV; mdbl = 0;
      end else if (mst == 1) begin
        if (mvel > my) begin my = 0; mst = 2; mvel = 0; end
        else begin
          my = my - mvel;
          if (mvel <= G) begin mst = 2; mvel = 0; end
          else mvel = mvel - G;
        end
      end else begin
        if (my + mvel >= YF) begin my = YF; mvel = 0; mst = 0; mland = 1; mdbl = 1; end
        else begin my = my + mvel; mvel = (mvel + G > VM) ? VM : mvel + G; end
      end
    end
    mjreq = 0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1; vsync = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    c_jump = 1'b0; game_en = 1'b1;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    model_reset();
  endtask

  // one video frame; jl is the jump level applied in the tick cycle
  task automatic frame(input bit jl);
    @(negedge pclk);
    vsync = 1'b1;
    if (jl && !prev_j) mjreq = 1;
    btn_jump = jl; prev_j = jl;
    @(posedge pclk); #1;
    model_tick(btn_left, btn_right, game_en);
    obs_land = landed; obs_cland = clnd;
    @(posedge pclk); #1;
    obs_land2 = landed;
    @(negedge pclk);
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (xpos !== 9'd160 || ypos !== 9'd220 || airborne !== 1'b0 || landed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got x=%0d y=%0d air=%b land=%b, want 160 220 0 0", xpos, ypos, airborne, landed);
    end
    for (int i = 0; i < 3; i++) begin
      frame(1'b0);
      n_checks++;
      if (xpos !== 9'd160 || ypos !== 9'd220 || airborne !== 1'b0 || obs_land !== 1'b0 || obs_land2 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_tick%0d: got x=%0d y=%0d air=%b land=%b/%b, want 160 220 0 0/0", i, xpos, ypos, airborne, obs_land, obs_land2);
      end
    end
  endtask

  task automatic test_horizontal();
    btn_right = 1'b1;
    for (int i = 0; i < 100; i++) begin
      frame(1'b0);
      n_checks++;
      if (xpos !== 9'(mx)) begin
        n_fail++;
        $display("FAIL right_step%0d: got x=%0d, want %0d", i, xpos, mx);
      end
    end
    n_checks++;
    if (xpos !== 9'd320) begin
      n_fail++;
      $display("FAIL right_saturate: got x=%0d, want 320", xpos);
    end
    btn_left = 1'b1;
    repeat (3) frame(1'b0);
    n_checks++;
    if (xpos !== 9'd320) begin
      n_fail++;
      $display("FAIL both_hold: got x=%0d, want 320", xpos);
    end
    btn_right = 1'b0;
    for (int i = 0; i < 90; i++) frame(1'b0);
    n_checks++;
    if (xpos !== 9'd0 || xpos !== 9'(mx)) begin
      n_fail++;
      $display("FAIL left_saturate: got x=%0d, want 0", xpos);
    end
    btn_left = 1'b0;
  endtask

  task automatic test_jump();
    bit done = 0;
    frame(1'b1);
    n_checks++;
    if (airborne !== 1'b1 || ypos !== 9'd220) begin
      n_fail++;
      $display("FAIL jump_tick1: got air=%b y=%0d, want 1 220", airborne, ypos);
    end
    frame(1'b0);
    n_checks++;
    if (ypos !== 9'd208) begin n_fail++; $display("FAIL jump_tick2: got y=%0d, want 208", ypos); end
    frame(1'b0);
    n_checks++;
    if (ypos !== 9'd197) begin n_fail++; $display("FAIL jump_tick3: got y=%0d, want 197", ypos); end
    for (int i = 0; i < 100 && !done; i++) begin
      frame(1'b0);
      n_checks++;
      if (ypos !== 9'(my) || airborne !== (mst != 0) || obs_land !== mland || obs_land2 !== 1'b0) begin
        n_fail++;
        $display("FAIL jump_frame%0d: got y=%0d air=%b land=%b/%b, want y=%0d air=%b land=%b/0",
                 i, ypos, airborne, obs_land, obs_land2, my, mst != 0, mland);
      end
      if (mland) done = 1;
    end
    n_checks++;
    if (!done || ypos !== 9'd220 || airborne !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_landing: landed_seen=%0d y=%0d air=%b, want 1 220 0", done, ypos, airborne);
    end
  endtask

  task automatic test_hold_jump();
    int lands = 0;
    for (int i = 0; i < 60; i++) begin
      frame(1'b1);
      if (mland) lands++;
      n_checks++;
      if (ypos !== 9'(my) || airborne !== (mst != 0) || obs_land !== mland) begin
        n_fail++;
        $display("FAIL hold_jump%0d: got y=%0d air=%b land=%b, want y=%0d air=%b land=%b",
                 i, ypos, airborne, obs_land, my, mst != 0, mland);
      end
    end
    n_checks++;
    if (lands != 1 || airborne !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_rejump: got landings=%0d air=%b, want 1 0", lands, airborne);
    end
    frame(1'b0);
  endtask

  task automatic test_freeze();
    logic [8:0] fy, fx;
    frame(1'b1);
    for (int i = 0; i < 16; i++) frame(1'b0);
    fy = ypos; fx = xpos;
    game_en = 1'b0; btn_right = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame(1'b0);
      n_checks++;
      if (ypos !== fy || xpos !== fx || airborne !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze%0d: got x=%0d y=%0d air=%b, want %0d %0d 1", i, xpos, ypos, airborne, fx, fy);
      end
    end
    game_en = 1'b1; btn_right = 1'b0;
    for (int i = 0; i < 30; i++) begin
      frame(1'b0);
      n_checks++;
      if (ypos !== 9'(my) || xpos !== 9'(mx) || airborne !== (mst != 0)) begin
        n_fail++;
        $display("FAIL resume%0d: got x=%0d y=%0d air=%b, want %0d %0d %b", i, xpos, ypos, airborne, mx, my, mst != 0);
      end
    end
  endtask

  task automatic test_edge_between();
    @(negedge pclk); btn_jump = 1'b1; mjreq = 1;
    repeat (2) @(negedge pclk); btn_jump = 1'b0; prev_j = 0;
    frame(1'b0);
    n_checks++;
    if (airborne !== 1'b1 || airborne !== (mst != 0)) begin
      n_fail++;
      $display("FAIL edge_between: got air=%b, want 1", airborne);
    end
    repeat (3) frame(1'b0);
    do_reset();
    #1;
    n_checks++;
    if (xpos !== 9'd160 || ypos !== 9'd220 || airborne !== 1'b0 || landed !== 1'b0) begin
      n_fail++;
      $display("FAIL midjump_reset: got x=%0d y=%0d air=%b land=%b, want 160 220 0 0", xpos, ypos, airborne, landed);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      btn_left = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      game_en = ($urandom_range(0, 9) != 0);
      frame(1'($urandom_range(0, 3) == 0));
      n_checks++;
      if (xpos !== 9'(mx) || ypos !== 9'(my) || airborne !== (mst != 0) || obs_land !== mland || obs_land2 !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d: got x=%0d y=%0d air=%b land=%b/%b, want x=%0d y=%0d air=%b land=%b/0",
                 i, xpos, ypos, airborne, obs_land, obs_land2, mx, my, mst != 0, mland);
      end
    end
    btn_left = 1'b0; btn_right = 1'b0; game_en = 1'b1;
  endtask

  task automatic test_ceiling();
    int ey = 0, ev = 0;
    bit done = 0;
    do_reset();
    @(negedge pclk); c_jump = 1'b1;
    frame(1'b0);
    n_checks++;
    if (cy !== 9'd100 || cair !== 1'b1) begin
      n_fail++; $display("FAIL ceil_tick1: got y=%0d air=%b, want 100 1", cy, cair);
    end
    frame(1'b0);
    n_checks++;
    if (cy !== 9'd0 || cair !== 1'b1) begin
      n_fail++; $display("FAIL ceil_clamp: got y=%0d air=%b, want 0 1", cy, cair);
    end
    for (int i = 0; i < 40 && !done; i++) begin
      frame(1'b0);
      if (ey + ev >= 100) begin ey = 100; done = 1; end
      else begin ey = ey + ev; ev = (ev + 1 > 10) ? 10 : ev + 1; end
      n_checks++;
      if (cy !== 9'(ey) || cair !== !done || obs_cland !== done) begin
        n_fail++;
        $display("FAIL ceil_fall%0d: got y=%0d air=%b land=%b, want %0d %b %b", i, cy, cair, obs_cland, ey, !done, done);
      end
    end
    c_jump = 1'b0;
  endtask

`ifdef PLAYER_CTL_DOUBLE_JUMP_EN
  task automatic test_double_jump();
    do_reset();
    frame(1'b1); frame(1'b0);
    for (int i = 0; i < 15; i++) frame(1'b0);
    frame(1'b1);
    n_checks++;
    if (mst != 1 || airborne !== 1'b1 || ypos !== 9'(my)) begin
      n_fail++; $display("FAIL double_jump: got y=%0d air=%b, want y=%0d rising", ypos, airborne, my);
    end
    frame(1'b0);
    for (int i = 0; i < 60; i++) begin
      frame(i == 2);
      n_checks++;
      if (ypos !== 9'(my) || airborne !== (mst != 0) || obs_land !== mland) begin
        n_fail++;
        $display("FAIL dbl_frame%0d: got y=%0d air=%b land=%b, want %0d %b %b", i, ypos, airborne, obs_land, my, mst != 0, mland);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_horizontal();
    test_jump();
    test_hold_jump();
    test_freeze();
    test_edge_between();
    test_random();
    test_ceiling();
`ifdef PLAYER_CTL_DOUBLE_JUMP_EN
    test_double_jump();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
